// File: rtl/frs_pkg.sv
// frs_pkg: shared constants and types for the FRS message receiver and queue
package frs_pkg;

    localparam logic [2:0] FMT_4DW_NODATA       = 3'b001;
    localparam logic [4:0] TYPE_MSG_RC          = 5'b10000;
    localparam logic [7:0] FRS_MSG_CODE_DEFAULT = 8'h09;

    typedef enum logic [2:0] {
        IDLE,
        DW1,
        DW2,
        DW3,
        SKIP,
        BAD_DRAIN
    } frs_rx_state_e;

    typedef struct packed {
        logic [15:0] function_id;
        logic [3:0]  reason;
    } frs_msg_t;

endpackage

// File: rtl/frs_message_receiver_sat_counter.sv
// sat_counter: increment-only counter that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    // next value: bump unless already saturated
    always_comb begin
        count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/frs_message_receiver.sv
// frs_message_receiver: parses RX Message TLP headers and emits FRS messages
module frs_message_receiver
    import frs_pkg::*;
#(
    parameter int         FUNCTION_ID_WIDTH = 16,
    parameter int         REASON_WIDTH      = 4,
    parameter logic [7:0] FRS_MSG_CODE      = FRS_MSG_CODE_DEFAULT,
    parameter int         COUNT_WIDTH       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frs_enable,
    input  logic                         tlp_valid,
    input  logic                         tlp_sop,
    input  logic                         tlp_eop,
    input  logic [31:0]                  tlp_data,
    output logic                         tlp_ready,
    output logic                         message_received,
    output logic [FUNCTION_ID_WIDTH-1:0] new_message_function_id,
    output logic [REASON_WIDTH-1:0]      new_message_reason,
    output logic [COUNT_WIDTH-1:0]       frs_msg_count,
    output logic [COUNT_WIDTH-1:0]       malformed_count
);

    frs_rx_state_e                state_q, state_d;
    logic                         len_ok_q, len_ok_d;
    logic [FUNCTION_ID_WIDTH-1:0] id_q, id_d;
    logic [FUNCTION_ID_WIDTH-1:0] fid_q, fid_d;
    logic [REASON_WIDTH-1:0]      reason_q, reason_d;
    logic                         pulse_q, pulse_d;
    logic                         acc, dw0_ok, code_ok, emit, malformed;
    logic                         unused_bits;

    assign tlp_ready   = !rst;
    assign acc         = tlp_valid && tlp_ready;
    assign dw0_ok      = tlp_data[31:29] == FMT_4DW_NODATA && tlp_data[28:24] == TYPE_MSG_RC;
    assign code_ok     = tlp_data[7:0] == FRS_MSG_CODE;
    assign unused_bits = ^tlp_data[23:10];

    // header walk: a sop always restarts at DW0, aborting any candidate in flight
    always_comb begin
        state_d   = state_q;
        len_ok_d  = len_ok_q;
        id_d      = id_q;
        emit      = 1'b0;
        malformed = 1'b0;
        if (acc) begin
            if (tlp_sop) begin
                malformed = state_q == DW2 || state_q == DW3;
                len_ok_d  = tlp_data[9:0] == 10'd0;
                state_d   = tlp_eop ? IDLE : (dw0_ok ? DW1 : SKIP);
            end else begin
                case (state_q)
                    DW1: begin
                        id_d      = tlp_data[31 -: FUNCTION_ID_WIDTH];
                        malformed = code_ok && tlp_eop;
                        state_d   = tlp_eop ? IDLE : (code_ok ? DW2 : SKIP);
                    end
                    DW2: begin
                        malformed = tlp_eop;
                        state_d   = tlp_eop ? IDLE : DW3;
                    end
                    DW3: begin
                        emit      = tlp_eop && len_ok_q;
                        malformed = !emit;
                        state_d   = tlp_eop ? IDLE : BAD_DRAIN;
                    end
                    SKIP, BAD_DRAIN: state_d = tlp_eop ? IDLE : state_q;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // emit path: latch the message fields alongside the pulse
    always_comb begin
        pulse_d  = emit && frs_enable;
        fid_d    = pulse_d ? id_q : fid_q;
        reason_d = pulse_d ? tlp_data[REASON_WIDTH-1:0] : reason_q;
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_ok_q <= 1'b0;
            id_q     <= '0;
            fid_q    <= '0;
            reason_q <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_ok_q <= len_ok_d;
            id_q     <= id_d;
            fid_q    <= fid_d;
            reason_q <= reason_d;
            pulse_q  <= pulse_d;
        end
    end

    assign message_received        = pulse_q;
    assign new_message_function_id = fid_q;
    assign new_message_reason      = reason_q;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_frs_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pulse_d),
        .count (frs_msg_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_mal_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (malformed && frs_enable),
        .count (malformed_count)
    );

endmodule

// File: tb/tb_frs_message_receiver.sv
// tb_frs_message_receiver: randomized scoreboard bench for the FRS message receiver
module tb_frs_message_receiver;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0, rst = 1'b1, frs_enable = 1'b1;
    logic          tlp_valid = 1'b0, tlp_sop = 1'b0, tlp_eop = 1'b0;
    logic [31:0]   tlp_data = '0;
    logic          tlp_ready, message_received;
    logic [15:0]   new_message_function_id;
    logic [3:0]    new_message_reason;
    logic [CW-1:0] frs_msg_count, malformed_count;

    frs_message_receiver #(.COUNT_WIDTH(CW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .frs_enable              (frs_enable),
        .tlp_valid               (tlp_valid),
        .tlp_sop                 (tlp_sop),
        .tlp_eop                 (tlp_eop),
        .tlp_data                (tlp_data),
        .tlp_ready               (tlp_ready),
        .message_received        (message_received),
        .new_message_function_id (new_message_function_id),
        .new_message_reason      (new_message_reason),
        .frs_msg_count           (frs_msg_count),
        .malformed_count         (malformed_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] id;
        logic [3:0]  r;
    } msg_t;

    msg_t        exp_q[$];
    int          checks = 0, failures = 0;
    int          m_frs = 0, m_mal = 0;
    logic [15:0] m_id = '0;
    logic [3:0]  m_r = '0;
    logic [31:0] pkt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // monitor: every pulse must match the oldest expected message
    always @(negedge clk) begin
        msg_t e;
        if (!rst && message_received) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=1 expected=0");
            end else begin
                e = exp_q.pop_front();
                chk("msg_id", new_message_function_id, e.id);
                chk("msg_reason", new_message_reason, e.r);
            end
        end
    end

    // reference: classify a TLP of n beats from its header fields
    task automatic model(input int n, input bit term);
        bit cand;
        cand = n >= 2 && pkt[0][31:29] == 3'b001 && pkt[0][28:24] == 5'b10000
               && pkt[1][7:0] == 8'h09;
        if (!cand || !frs_enable) return;
        if (term && n == 4 && pkt[0][9:0] == 10'd0) begin
            exp_q.push_back('{id: pkt[1][31:16], r: pkt[3][3:0]});
            m_id  = pkt[1][31:16];
            m_r   = pkt[3][3:0];
            m_frs = (m_frs < MAX) ? m_frs + 1 : MAX;
        end else begin
            m_mal = (m_mal < MAX) ? m_mal + 1 : MAX;
        end
    endtask

    task automatic beat(input bit s, input bit e, input logic [31:0] d);
        if ($urandom_range(0, 3) == 0) begin
            tlp_valid = 1'b0;
            tlp_sop   = 1'($urandom);
            tlp_eop   = 1'($urandom);
            tlp_data  = $urandom;
            @(posedge clk); #1;
        end
        tlp_valid = 1'b1;
        tlp_sop   = s;
        tlp_eop   = e;
        tlp_data  = d;
        @(posedge clk); #1;
        tlp_valid = 1'b0;
        tlp_sop   = 1'b0;
        tlp_eop   = 1'b0;
    endtask

    task automatic send(input int n, input bit term);
        model(n, term);
        for (int i = 0; i < n; i++) beat(i == 0, term && i == n - 1, pkt[i]);
    endtask

    task automatic mk_frs(input logic [15:0] id, input logic [3:0] r);
        pkt[0] = 32'h3000_0000;
        pkt[1] = {id, 8'($urandom), 8'h09};
        pkt[2] = $urandom;
        pkt[3] = {28'($urandom), r};
        for (int i = 4; i < 8; i++) pkt[i] = $urandom;
    endtask

    task automatic idle_check();
        tlp_valid = 1'b0;
        @(posedge clk); #1;
        chk("frs_msg_count", frs_msg_count, m_frs);
        chk("malformed_count", malformed_count, m_mal);
        chk("held_id", new_message_function_id, m_id);
        chk("held_reason", new_message_reason, m_r);
        chk("pending_msgs", exp_q.size(), 0);
    endtask

    task automatic reset_check();
        chk("rst_pulse", message_received, 0);
        chk("rst_ready", tlp_ready, 0);
        chk("rst_id", new_message_function_id, 0);
        chk("rst_reason", new_message_reason, 0);
        chk("rst_frs_cnt", frs_msg_count, 0);
        chk("rst_mal_cnt", malformed_count, 0);
    endtask

    initial begin
        int k, n, r;
        bit term;
        repeat (3) @(posedge clk);
        #1;
        reset_check();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", tlp_ready, 1);
        // single valid FRS
        pkt[0] = 32'h3000_0000; pkt[1] = 32'hABCD_0009; pkt[2] = 32'h0; pkt[3] = 32'h0000_0005;
        send(4, 1);
        idle_check();
        // non-FRS code then a back-to-back valid FRS
        pkt[1] = 32'hABCD_0014;
        send(4, 1);
        mk_frs(16'h1234, 4'h3);
        send(4, 1);
        idle_check();
        // eop on DW2, then valid FRS
        mk_frs(16'h5555, 4'h1);
        send(3, 1);
        mk_frs(16'h6789, 4'h2);
        send(4, 1);
        idle_check();
        // sop arrives where DW2 was due
        mk_frs(16'h1111, 4'h7);
        send(2, 0);
        mk_frs(16'h2222, 4'h9);
        send(4, 1);
        idle_check();
        // drive the message counter into saturation
        for (int i = 0; i < MAX + 3; i++) begin
            mk_frs(16'(i), 4'(i));
            send(4, 1);
        end
        idle_check();
        // disabled: nothing emitted or counted
        frs_enable = 1'b0;
        mk_frs(16'hDEAD, 4'hE);
        send(4, 1);
        send(3, 1);
        idle_check();
        frs_enable = 1'b1;
        // reset part way through an FRS
        mk_frs(16'hBEEF, 4'hC);
        beat(1, 0, pkt[0]);
        beat(0, 0, pkt[1]);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_check();
        rst = 1'b0;
        m_frs = 0; m_mal = 0; m_id = '0; m_r = '0;
        beat(0, 0, pkt[2]);
        beat(0, 1, pkt[3]);
        idle_check();
        mk_frs(16'hCAFE, 4'h4);
        send(4, 1);
        idle_check();
        // randomized groups, some TLPs cut short by the next sop
        for (int g = 0; g < 80; g++) begin
            frs_enable = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 3) == 0) beat(0, 1'($urandom), $urandom);
            k = $urandom_range(1, 3);
            for (int t = 0; t < k; t++) begin
                mk_frs(16'($urandom), 4'($urandom));
                r = $urandom_range(0, 9);
                if (r == 0) pkt[0][31:24] = 8'($urandom);
                if (r == 1) pkt[1][7:0] = 8'($urandom);
                if (r == 2) pkt[0][9:0] = 10'($urandom_range(1, 1023));
                if (r == 3) pkt[0][23:10] = 14'($urandom);
                n = ($urandom_range(0, 9) < 7) ? 4 : $urandom_range(1, 6);
                term = (t == k - 1) || ($urandom_range(0, 2) != 0);
                send(n, term);
            end
            idle_check();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
